// File: rtl/alu_pkg.sv
// Shared definitions for the alu_muldiv execute-stage ALU.
// Contents:
//   - 5-bit opcode encodings ALU_ADD .. ALU_REMU
//   - alu_state_e : handshake FSM states (IDLE, BUSY, DONE)
//   - is_muldiv / is_div / is_legal : opcode classification helpers
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'h00;
    localparam logic [4:0] ALU_SUB    = 5'h01;
    localparam logic [4:0] ALU_SLL    = 5'h02;
    localparam logic [4:0] ALU_SLT    = 5'h03;
    localparam logic [4:0] ALU_SLTU   = 5'h04;
    localparam logic [4:0] ALU_XOR    = 5'h05;
    localparam logic [4:0] ALU_SRA    = 5'h06;
    localparam logic [4:0] ALU_SRL    = 5'h07;
    localparam logic [4:0] ALU_OR     = 5'h08;
    localparam logic [4:0] ALU_AND    = 5'h09;
    localparam logic [4:0] ALU_MUL    = 5'h0A;
    localparam logic [4:0] ALU_MULH   = 5'h0B;
    localparam logic [4:0] ALU_MULHSU = 5'h0C;
    localparam logic [4:0] ALU_MULHU  = 5'h0D;
    localparam logic [4:0] ALU_DIV    = 5'h0E;
    localparam logic [4:0] ALU_DIVU   = 5'h0F;
    localparam logic [4:0] ALU_REM    = 5'h10;
    localparam logic [4:0] ALU_REMU   = 5'h11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // mul, mulh, mulhsu, mulhu, div, divu, rem, remu
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    // div, divu, rem, remu
    function automatic logic is_div(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op <= ALU_REMU;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned radix-2 multiply / restoring divide datapath.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : synchronous abort; drops the running operation and counter
//   start_i     : load a_i/b_i and begin XLEN iterations
//   is_div_i    : 1 = divide a_i by b_i, 0 = multiply a_i by b_i
//   a_i, b_i    : unsigned operands (multiplier/multiplicand, dividend/divisor)
//   done_o      : one-cycle pulse during the final iteration
//   hi_o, lo_o  : value after the current iteration; valid with done_o.
//                 mul: {hi_o, lo_o} = product.  div: hi_o = rem, lo_o = quot.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  hi_q, lo_q, b_q;
    logic [XLEN-1:0]  hi_d, lo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, div_q;

    logic [XLEN:0]    step_sum, step_shift, step_diff;
    logic             step_ge;

    // One radix-2 step. The multiplier lives in lo_q and is consumed from
    // the LSB while the partial product shifts in from the top; the
    // dividend lives in lo_q and is consumed from the MSB while quotient
    // bits shift in at the bottom.
    always_comb begin
        step_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        step_shift = {hi_q, lo_q[XLEN-1]};
        step_diff  = step_shift - {1'b0, b_q};
        step_ge    = (step_shift >= {1'b0, b_q});
        if (div_q) begin
            // Remainder stays below the divisor, so the difference fits XLEN bits.
            hi_d = step_ge ? step_diff[XLEN-1:0] : step_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], step_ge};
        end else begin
            hi_d = step_sum[XLEN:1];
            lo_d = {step_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            div_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
            div_q  <= is_div_i;
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(XLEN - 1);
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign done_o = busy_q && (cnt_q == '0);
    assign hi_o   = hi_d;
    assign lo_o   = lo_d;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle base integer ops plus iterative M-extension.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : synchronous kill of any in-flight or held op
//   in_valid / in_ready     : operation handshake from decode/register-read
//   alu_immediate_enable    : operand 2 = immediate_data instead of reg b
//   register_read_data_a/b  : register operands
//   immediate_data          : immediate operand
//   alu_operation           : 5-bit opcode (see alu_pkg)
//   out_valid / out_ready   : result handshake towards writeback
//   alu_out                 : result
//   illegal_op              : result is for an undefined opcode (alu_out = 0)
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload until then, and in_ready is forced low while
// flush is high. The result and illegal_op stay stable while out_valid is
// high and out_ready is low.
// XLEN must be 32 or 64.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            alu_immediate_enable,
    input  logic [XLEN-1:0] register_read_data_a,
    input  logic [XLEN-1:0] register_read_data_b,
    input  logic [XLEN-1:0] immediate_data,
    input  logic [4:0]      alu_operation,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            illegal_op
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e        state_q;
    logic [XLEN-1:0]   alu_out_q;
    logic              illegal_q;
    logic [4:0]        op_q;
    logic              neg_q;

    logic [XLEN-1:0]   op_a, op_b;
    logic [SHAMT_W-1:0] shamt;
    logic              accept, start;
    logic              div_by_zero, div_overflow, early;
    logic              sign_a, sign_b, neg_d;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   base_res, early_res, result_d;

    logic              md_done;
    logic [XLEN-1:0]   md_hi, md_lo;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   final_res;

    assign op_a  = register_read_data_a;
    assign op_b  = alu_immediate_enable ? immediate_data : register_read_data_b;
    assign shamt = op_b[SHAMT_W-1:0];

    assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        base_res = '0;
        case (alu_operation)
            ALU_ADD:  base_res = op_a + op_b;
            ALU_SUB:  base_res = op_a - op_b;
            ALU_SLL:  base_res = op_a << shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  base_res = op_a ^ op_b;
            ALU_SRA:  base_res = $unsigned($signed(op_a) >>> shamt);
            ALU_SRL:  base_res = op_a >> shamt;
            ALU_OR:   base_res = op_a | op_b;
            ALU_AND:  base_res = op_a & op_b;
            default:  base_res = '0;
        endcase
    end

    // Divide-by-zero and the signed INT_MIN / -1 case bypass the iterator
    // and complete with base-op latency.
    always_comb begin
        div_by_zero  = is_div(alu_operation) && (op_b == '0);
        div_overflow = ((alu_operation == ALU_DIV) || (alu_operation == ALU_REM)) &&
                       (op_a == INT_MIN) && (op_b == '1);
        early        = div_by_zero || div_overflow;
        early_res    = '0;
        if (div_by_zero) begin
            early_res = ((alu_operation == ALU_DIV) || (alu_operation == ALU_DIVU)) ? '1 : op_a;
        end else if (div_overflow) begin
            early_res = (alu_operation == ALU_DIV) ? INT_MIN : '0;
        end
        result_d = !is_legal(alu_operation) ? '0 : (early ? early_res : base_res);
    end

    // Sign flags only for operands the opcode treats as signed; the
    // iterator then works on magnitudes. Remainder takes the dividend's
    // sign, everything else the xor of both signs.
    always_comb begin
        sign_a = ((alu_operation == ALU_MULH) || (alu_operation == ALU_MULHSU) ||
                  (alu_operation == ALU_DIV)  || (alu_operation == ALU_REM)) && op_a[XLEN-1];
        sign_b = ((alu_operation == ALU_MULH) || (alu_operation == ALU_DIV) ||
                  (alu_operation == ALU_REM)) && op_b[XLEN-1];
        mag_a  = sign_a ? -op_a : op_a;
        mag_b  = sign_b ? -op_b : op_b;
        neg_d  = ((alu_operation == ALU_REM) || (alu_operation == ALU_REMU)) ? sign_a
                                                                            : (sign_a ^ sign_b);
    end

    assign start = accept && is_muldiv(alu_operation) && !early;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (flush),
        .start_i  (start),
        .is_div_i (is_div(alu_operation)),
        .a_i      (mag_a),
        .b_i      (mag_b),
        .done_o   (md_done),
        .hi_o     (md_hi),
        .lo_o     (md_lo)
    );

    // Sign correction on the final iteration's value. mulh/mulhsu need the
    // full double-width negation so the borrow reaches the high half.
    always_comb begin
        prod_mag = {md_hi, md_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        case (op_q)
            ALU_MUL:                        final_res = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:              final_res = neg_q ? -md_lo : md_lo;
            default:                        final_res = neg_q ? -md_hi : md_hi;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
            illegal_q <= 1'b0;
            op_q      <= ALU_ADD;
            neg_q     <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else if (accept) begin
            if (start) begin
                state_q <= BUSY;
                op_q    <= alu_operation;
                neg_q   <= neg_d;
            end else begin
                state_q   <= DONE;
                alu_out_q <= result_d;
                illegal_q <= !is_legal(alu_operation);
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (md_done) begin
                        state_q   <= DONE;
                        alu_out_q <= final_res;
                        illegal_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = (state_q == DONE);
    assign alu_out    = alu_out_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int XLEN = 32;
    // Scoreboard entry: {has_hand, hand_value, illegal, result, valid_cycle}
    localparam int EW = 1 + 32 + 1 + 32 + 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            alu_immediate_enable;
    logic [XLEN-1:0] register_read_data_a;
    logic [XLEN-1:0] register_read_data_b;
    logic [XLEN-1:0] immediate_data;
    logic [4:0]      alu_operation;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic            illegal_op;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .alu_immediate_enable (alu_immediate_enable),
        .register_read_data_a (register_read_data_a),
        .register_read_data_b (register_read_data_b),
        .immediate_data       (immediate_data),
        .alu_operation        (alu_operation),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .alu_out              (alu_out),
        .illegal_op           (illegal_op)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Returns {illegal, result} from the architectural definition of each op.
    function automatic logic [32:0] model_res(input logic [4:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [31:0]     r;
        logic            ill;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        r   = 32'h0;
        ill = 1'b0;
        case (op)
            ALU_ADD:    r = a + b;
            ALU_SUB:    r = a - b;
            ALU_SLL:    r = a << b[4:0];
            ALU_SLT:    r = {31'h0, ($signed(a) < $signed(b))};
            ALU_SLTU:   r = {31'h0, (a < b)};
            ALU_XOR:    r = a ^ b;
            ALU_SRA:    r = $signed(a) >>> b[4:0];
            ALU_SRL:    r = a >> b[4:0];
            ALU_OR:     r = a | b;
            ALU_AND:    r = a & b;
            ALU_MUL:    begin sp = sa * sb; r = sp[31:0]; end
            ALU_MULH:   begin sp = sa * sb; r = sp[63:32]; end
            ALU_MULHSU: begin sp = sa * longint'(ub); r = sp[63:32]; end
            ALU_MULHU:  begin up = ua * ub; r = up[63:32]; end
            ALU_DIV: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin sp = sa / sb; r = sp[31:0]; end
            end
            ALU_DIVU: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else begin up = ua / ub; r = up[31:0]; end
            end
            ALU_REM: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin sp = sa % sb; r = sp[31:0]; end
            end
            ALU_REMU: begin
                if (b == 32'h0) r = a;
                else begin up = ua % ub; r = up[31:0]; end
            end
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    // Extra cycles beyond the one-cycle base latency.
    function automatic int model_extra(input logic [4:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        if (op >= ALU_MUL && op <= ALU_MULHU) return XLEN;
        if (op >= ALU_DIV && op <= ALU_REMU) begin
            if (b == 32'h0) return 0;
            if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 0;
            return XLEN;
        end
        return 0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [EW-1:0] front;
    bit            exp_valid;

    always @(negedge clk) begin
        exp_valid = 1'b0;
        front     = '0;
        if (exp_q.size() > 0) begin
            front     = exp_q[0];
            exp_valid = (cyc >= int'(front[31:0]));
        end
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready),
            32'(!flush && (exp_q.size() == 0 || (exp_valid && out_ready))));
        if (exp_valid) begin
            chk("alu_out", alu_out, front[63:32]);
            chk("illegal_op", 32'(illegal_op), 32'(front[64]));
            if (out_ready && !flush) begin
                if (front[97]) chk("hand_value", alu_out, front[96:65]);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_imm, input logic [31:0] hand);
        int          waited;
        logic [32:0] m;
        waited = 0;
        alu_operation        = op;
        register_read_data_a = a;
        alu_immediate_enable = use_imm;
        if (use_imm) begin
            immediate_data       = b;
            register_read_data_b = $urandom;
        end else begin
            register_read_data_b = b;
            immediate_data       = $urandom;
        end
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: op %h not accepted, in_ready %b expected 1", op, in_ready);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            m = model_res(op, a, b);
            exp_q.push_back({1'b1, hand, m[32], m[31:0], 32'(cyc + model_extra(op, a, b))});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        rst_n                = 1'b0;
        flush                = 1'b0;
        in_valid             = 1'b0;
        out_ready            = 1'b1;
        alu_immediate_enable = 1'b0;
        register_read_data_a = '0;
        register_read_data_b = '0;
        immediate_data       = '0;
        alu_operation        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_alu_out", alu_out, 32'h0);
        chk("rst_illegal_op", 32'(illegal_op), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Back-to-back base ops, one per cycle.
        issue(ALU_ADD,  32'hFFFF_FFFF, 32'h1,         0, 32'h0);
        issue(ALU_SUB,  32'h0,         32'h1,         0, 32'hFFFF_FFFF);
        issue(ALU_SRA,  32'h8000_0000, 32'h4,         1, 32'hF800_0000);
        issue(ALU_SLTU, 32'h1,         32'hFFFF_FFFF, 0, 32'h1);
        issue(ALU_SLL,  32'h1,         32'd31,        1, 32'h8000_0000);
        issue(ALU_SLL,  32'h1,         32'h21,        0, 32'h2);
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'h1,         0, 32'h1);
        issue(ALU_SLT,  32'h1,         32'hFFFF_FFFF, 0, 32'h0);
        issue(ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0);
        issue(ALU_SRL,  32'h8000_0000, 32'd31,        1, 32'h1);
        issue(ALU_SRA,  32'h7FFF_FFFF, 32'h3F,        0, 32'h0);
        issue(ALU_OR,   32'h0F0F_0000, 32'h0000_F0F0, 0, 32'h0F0F_F0F0);
        issue(ALU_AND,  32'hFFFF_0000, 32'h1234_5678, 0, 32'h1234_0000);
        drain();

        // Multiplies.
        issue(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000);
        // in_valid offered while busy, then withdrawn without acceptance.
        alu_operation        = ALU_ADD;
        register_read_data_a = 32'h11;
        register_read_data_b = 32'h22;
        alu_immediate_enable = 1'b0;
        in_valid             = 1'b1;
        idle(3);
        in_valid = 1'b0;
        drain();
        issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
        issue(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
        issue(ALU_MUL,    32'hFFFF_FFFF, 32'h3,         0, 32'hFFFF_FFFD);
        drain();

        // Early-out divides.
        issue(ALU_DIV,  32'h7,         32'h0,         0, 32'hFFFF_FFFF);
        issue(ALU_REM,  32'h7,         32'h0,         0, 32'h7);
        issue(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        issue(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0);
        issue(ALU_DIVU, 32'h5,         32'h0,         0, 32'hFFFF_FFFF);
        issue(ALU_REMU, 32'h5,         32'h0,         1, 32'h5);
        drain();

        // Iterative divides.
        issue(ALU_DIV,  32'hFFFF_FFF9, 32'h2,         0, 32'hFFFF_FFFD);
        issue(ALU_REM,  32'hFFFF_FFF9, 32'h2,         0, 32'hFFFF_FFFF);
        issue(ALU_DIVU, 32'd100,       32'd7,         0, 32'd14);
        issue(ALU_REMU, 32'd100,       32'd7,         1, 32'd2);
        issue(ALU_DIV,  32'h7,         32'hFFFF_FFFE, 0, 32'hFFFF_FFFD);
        issue(ALU_REM,  32'h7,         32'hFFFF_FFFE, 0, 32'h1);
        issue(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0);
        issue(ALU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        drain();

        // Backpressure: result held for several cycles after a multiply.
        out_ready = 1'b0;
        issue(ALU_MUL, 32'h1234_5678, 32'h9, 0, 32'hA3D7_0A38);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        idle(5);
        out_ready = 1'b1;
        drain();

        // Illegal opcodes.
        issue(5'h1F, 32'hDEAD_BEEF, 32'h1234_5678, 0, 32'h0);
        issue(5'h12, 32'h1,         32'h2,         0, 32'h0);
        issue(ALU_ADD, 32'h4,       32'h5,         0, 32'h9);
        drain();

        // Flush in the tenth busy cycle of a divide.
        issue(ALU_DIV, 32'd1000, 32'd3, 0, 32'd333);
        idle(9);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        exp_q.delete();
        issue(ALU_ADD, 32'd2, 32'd3, 0, 32'd5);
        drain();

        // Reset pulsed mid-divide.
        issue(ALU_DIVU, 32'hFFFF_FFFF, 32'd3, 0, 32'h5555_5555);
        idle(15);
        rst_n = 1'b0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_alu_out", alu_out, 32'h0);
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd2, 32'd3, 0, 32'd5);
        drain();

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
